memory_stage: RTL and testbench

Pipeline stage between execute and writeback. Registers execute results, performs `OP_LDW`/`OP_STW` data-memory accesses over a request/acknowledge port, and handles one memory-mapped LED register. It presents `O_Opcode`/`O_ALUOut`/`O_MemOut`/`O_DestRegIdx`/stall qualifiers to the writeback stage. While a memory access is outstanding it stalls upstream and injects bubbles downstream.

---
 rtl/memory_stage_pkg.sv | 17 +
 rtl/memory_stage_if.sv | 25 ++
 rtl/memory_stage_dmem_port_ctrl.sv | 82 ++++++++
 rtl/memory_stage.sv | 109 ++++++++++
 tb/tb_memory_stage.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/memory_stage_pkg.sv
// rtl/memory_stage_pkg.sv - shared widths, opcodes and MMIO address for the memory stage
package memory_stage_pkg;

    localparam int OPCODE_WIDTH = 8;
    localparam int REG_WIDTH    = 16;

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD_D = 8'h10;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDW   = 8'h40;
    localparam logic [OPCODE_WIDTH-1:0] OP_STW   = 8'h41;

    localparam logic [REG_WIDTH-1:0] ADDR_LEDR = 16'hF000;

    function automatic logic isMemOp(input logic [OPCODE_WIDTH-1:0] op);
        return (op == OP_LDW) || (op == OP_STW);
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// rtl/memory_stage_if.sv - data-memory request/acknowledge port
// master: drives O_MemReq/O_MemWe/O_MemAddr/O_MemWData, samples I_MemAck/I_MemRData
// slave : the data memory side
interface memory_stage_if
    import memory_stage_pkg::*;
#(
    parameter int DMEM_ADDR_WIDTH = 11
);
    logic                       O_MemReq;
    logic                       O_MemWe;
    logic [DMEM_ADDR_WIDTH-1:0] O_MemAddr;
    logic [REG_WIDTH-1:0]       O_MemWData;
    logic                       I_MemAck;
    logic [REG_WIDTH-1:0]       I_MemRData;

    modport master (
        output O_MemReq, O_MemWe, O_MemAddr, O_MemWData,
        input  I_MemAck, I_MemRData
    );

    modport slave (
        input  O_MemReq, O_MemWe, O_MemAddr, O_MemWData,
        output I_MemAck, I_MemRData
    );
endinterface

// File: rtl/memory_stage_dmem_port_ctrl.sv
// rtl/memory_stage_dmem_port_ctrl.sv - IDLE/WAIT memory access FSM with timeout
// Ports: I_CLOCK/I_RESET_N; startReq/startWe/startAddr/startWData launch an access;
// portIdle, accessDone (ack seen), accessTimeout (abort), memErr (sticky); mem = memory port.
module dmem_port_ctrl
    import memory_stage_pkg::*;
#(
    parameter int DMEM_ADDR_WIDTH = 11,
    parameter int MEM_TIMEOUT     = 255
)(
    input  logic                       I_CLOCK,
    input  logic                       I_RESET_N,
    input  logic                       startReq,
    input  logic                       startWe,
    input  logic [DMEM_ADDR_WIDTH-1:0] startAddr,
    input  logic [REG_WIDTH-1:0]       startWData,
    output logic                       portIdle,
    output logic                       accessDone,
    output logic                       accessTimeout,
    output logic                       memErr,
    memory_stage_if.master             mem
);
    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    // The timeout fires on the MEM_TIMEOUT-th WAIT cycle without an ack.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_WAIT} portState_t;

    portState_t       state, stateNext;
    logic [CNT_W-1:0] waitCnt;

    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) state <= S_IDLE;
        else            state <= stateNext;
    end

    always_comb begin
        stateNext     = state;
        accessDone    = 1'b0;
        accessTimeout = 1'b0;
        case (state)
            S_IDLE: if (startReq) stateNext = S_WAIT;
            S_WAIT: begin
                // Ack takes priority over a coinciding timeout.
                if (mem.I_MemAck) begin
                    accessDone = 1'b1;
                    stateNext  = S_IDLE;
                end else if (waitCnt == TIMEOUT_LAST) begin
                    accessTimeout = 1'b1;
                    stateNext     = S_IDLE;
                end
            end
            default: stateNext = S_IDLE;
        endcase
    end

    assign portIdle = (state == S_IDLE);

    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            waitCnt        <= '0;
            memErr         <= 1'b0;
            mem.O_MemReq   <= 1'b0;
            mem.O_MemWe    <= 1'b0;
            mem.O_MemAddr  <= '0;
            mem.O_MemWData <= '0;
        end else if (state == S_IDLE) begin
            if (startReq) begin
                waitCnt        <= '0;
                mem.O_MemReq   <= 1'b1;
                mem.O_MemWe    <= startWe;
                mem.O_MemAddr  <= startAddr;
                mem.O_MemWData <= startWData;
            end
        end else if (accessDone || accessTimeout) begin
            mem.O_MemReq <= 1'b0;
            mem.O_MemWe  <= 1'b0;
            if (accessTimeout) memErr <= 1'b1;
        end else begin
            waitCnt <= waitCnt + 1'b1;
        end
    end
endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - execute-to-writeback pipeline stage with data memory and LED MMIO
// Inputs : I_CLOCK, I_RESET_N, I_LOCK, I_Opcode, I_ALUOut, I_StoreData, I_DestRegIdx, qualifiers
// Outputs: O_Stall, registered O_LOCK/O_Opcode/O_ALUOut/O_MemOut/O_DestRegIdx/qualifiers,
//          O_LEDR, O_MemErr; memPort carries the data-memory request/ack signals.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int DMEM_ADDR_WIDTH = 11,
    parameter int MEM_TIMEOUT     = 255
)(
    input  logic                    I_CLOCK,
    input  logic                    I_RESET_N,
    input  logic                    I_LOCK,
    input  logic [OPCODE_WIDTH-1:0] I_Opcode,
    input  logic [REG_WIDTH-1:0]    I_ALUOut,
    input  logic [REG_WIDTH-1:0]    I_StoreData,
    input  logic [3:0]              I_DestRegIdx,
    input  logic                    I_FetchStall,
    input  logic                    I_DepStall,
    output logic                    O_Stall,
    output logic                    O_LOCK,
    output logic [OPCODE_WIDTH-1:0] O_Opcode,
    output logic [REG_WIDTH-1:0]    O_ALUOut,
    output logic [REG_WIDTH-1:0]    O_MemOut,
    output logic [3:0]              O_DestRegIdx,
    output logic                    O_FetchStall,
    output logic                    O_DepStall,
    output logic [REG_WIDTH-1:0]    O_LEDR,
    output logic                    O_MemErr,
    memory_stage_if.master          memPort
);
    logic portIdle, accessDone, accessTimeout;
    logic liveMem, isLed, startReq;

    logic [OPCODE_WIDTH-1:0] heldOpcode;
    logic [REG_WIDTH-1:0]    heldALUOut;
    logic [3:0]              heldDestRegIdx;

    assign liveMem  = I_LOCK && !I_FetchStall && !I_DepStall && isMemOp(I_Opcode);
    assign isLed    = (I_ALUOut == ADDR_LEDR);
    assign startReq = portIdle && liveMem && !isLed;
    assign O_Stall  = !portIdle;

    dmem_port_ctrl #(
        .DMEM_ADDR_WIDTH (DMEM_ADDR_WIDTH),
        .MEM_TIMEOUT     (MEM_TIMEOUT)
    ) u_port (
        .I_CLOCK       (I_CLOCK),
        .I_RESET_N     (I_RESET_N),
        .startReq      (startReq),
        .startWe       (I_Opcode == OP_STW),
        .startAddr     (I_ALUOut[DMEM_ADDR_WIDTH:1]),
        .startWData    (I_StoreData),
        .portIdle      (portIdle),
        .accessDone    (accessDone),
        .accessTimeout (accessTimeout),
        .memErr        (O_MemErr),
        .mem           (memPort)
    );

    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            O_LOCK         <= 1'b0;
            O_Opcode       <= '0;
            O_ALUOut       <= '0;
            O_MemOut       <= '0;
            O_DestRegIdx   <= '0;
            O_FetchStall   <= 1'b0;
            O_DepStall     <= 1'b0;
            O_LEDR         <= '0;
            heldOpcode     <= '0;
            heldALUOut     <= '0;
            heldDestRegIdx <= '0;
        end else if (accessDone || accessTimeout) begin
            // Release the held instruction; a timed-out one goes out squashed.
            O_LOCK       <= 1'b1;
            O_Opcode     <= heldOpcode;
            O_ALUOut     <= heldALUOut;
            O_DestRegIdx <= heldDestRegIdx;
            O_FetchStall <= 1'b0;
            O_DepStall   <= accessTimeout;
            if (accessDone && heldOpcode == OP_LDW) O_MemOut <= memPort.I_MemRData;
        end else if (portIdle) begin
            if (startReq) begin
                O_LOCK         <= 1'b1;
                O_Opcode       <= '0;
                O_ALUOut       <= '0;
                O_DestRegIdx   <= '0;
                O_FetchStall   <= 1'b0;
                O_DepStall     <= 1'b1;
                heldOpcode     <= I_Opcode;
                heldALUOut     <= I_ALUOut;
                heldDestRegIdx <= I_DestRegIdx;
            end else begin
                O_LOCK       <= I_LOCK;
                O_Opcode     <= I_Opcode;
                O_ALUOut     <= I_ALUOut;
                O_DestRegIdx <= I_DestRegIdx;
                O_FetchStall <= I_FetchStall;
                O_DepStall   <= I_DepStall;
                if (liveMem && isLed) begin
                    if (I_Opcode == OP_STW) O_LEDR   <= I_StoreData;
                    else                    O_MemOut <= O_LEDR;
                end
            end
        end
        // WAIT without ack/timeout: the bubble stays on the outputs.
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed self-checking bench for memory_stage
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic                    clk = 1'b0;
    logic                    rstN;
    logic                    iLock;
    logic [OPCODE_WIDTH-1:0] iOpcode;
    logic [REG_WIDTH-1:0]    iALUOut, iStoreData;
    logic [3:0]              iDest;
    logic                    iFetchStall, iDepStall;
    logic                    oStall, oLock, oFetchStall, oDepStall, oMemErr;
    logic [OPCODE_WIDTH-1:0] oOpcode;
    logic [REG_WIDTH-1:0]    oALUOut, oMemOut, oLEDR;
    logic [3:0]              oDest;

    int errors = 0;
    int checks = 0;

    memory_stage_if #(.DMEM_ADDR_WIDTH(11)) memBus ();

    memory_stage #(.DMEM_ADDR_WIDTH(11), .MEM_TIMEOUT(4)) dut (
        .I_CLOCK      (clk),
        .I_RESET_N    (rstN),
        .I_LOCK       (iLock),
        .I_Opcode     (iOpcode),
        .I_ALUOut     (iALUOut),
        .I_StoreData  (iStoreData),
        .I_DestRegIdx (iDest),
        .I_FetchStall (iFetchStall),
        .I_DepStall   (iDepStall),
        .O_Stall      (oStall),
        .O_LOCK       (oLock),
        .O_Opcode     (oOpcode),
        .O_ALUOut     (oALUOut),
        .O_MemOut     (oMemOut),
        .O_DestRegIdx (oDest),
        .O_FetchStall (oFetchStall),
        .O_DepStall   (oDepStall),
        .O_LEDR       (oLEDR),
        .O_MemErr     (oMemErr),
        .memPort      (memBus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [OPCODE_WIDTH-1:0] op, input logic [15:0] alu,
                         input logic [15:0] sd, input logic [3:0] dst, input logic dep);
        iLock = 1'b1; iOpcode = op; iALUOut = alu; iStoreData = sd; iDest = dst;
        iFetchStall = 1'b0; iDepStall = dep;
    endtask

    initial begin
        rstN = 1'b0;
        memBus.I_MemAck = 1'b1;
        memBus.I_MemRData = 16'hDEAD;
        drive(OP_ADD_D, 16'h7777, 16'h0, 4'd1, 1'b0);
        step(); step();
        // Reset with ack held high
        chk("rst_lock",   32'(oLock), 32'd0);
        chk("rst_alu",    32'(oALUOut), 32'h0);
        chk("rst_memout", 32'(oMemOut), 32'h0);
        chk("rst_req",    32'(memBus.O_MemReq), 32'd0);
        chk("rst_stall",  32'(oStall), 32'd0);
        chk("rst_led",    32'(oLEDR), 32'h0);
        chk("rst_err",    32'(oMemErr), 32'd0);
        rstN = 1'b1;
        memBus.I_MemAck = 1'b0;

        // Live ALU op
        drive(OP_ADD_D, 16'h1234, 16'h0, 4'd3, 1'b0);
        step();
        chk("add_alu",   32'(oALUOut), 32'h1234);
        chk("add_dest",  32'(oDest), 32'd3);
        chk("add_dep",   32'(oDepStall), 32'd0);
        chk("add_stall", 32'(oStall), 32'd0);
        chk("add_lock",  32'(oLock), 32'd1);

        // LDW 0x0010, ack sampled on the third edge after accept
        drive(OP_LDW, 16'h0010, 16'h0, 4'd5, 1'b0);
        step();
        chk("ldw_req",    32'(memBus.O_MemReq), 32'd1);
        chk("ldw_addr",   32'(memBus.O_MemAddr), 32'd8);
        chk("ldw_we",     32'(memBus.O_MemWe), 32'd0);
        chk("ldw_stall0", 32'(oStall), 32'd1);
        chk("ldw_bub0",   32'(oDepStall), 32'd1);
        step();
        chk("ldw_stall1", 32'(oStall), 32'd1);
        chk("ldw_bub1",   32'(oDepStall), 32'd1);
        step();
        chk("ldw_stall2", 32'(oStall), 32'd1);
        chk("ldw_addr2",  32'(memBus.O_MemAddr), 32'd8);
        memBus.I_MemAck = 1'b1;
        memBus.I_MemRData = 16'hBEEF;
        step();
        memBus.I_MemAck = 1'b0;
        chk("ldw_stall3", 32'(oStall), 32'd0);
        chk("ldw_reqoff", 32'(memBus.O_MemReq), 32'd0);
        chk("ldw_data",   32'(oMemOut), 32'hBEEF);
        chk("ldw_dep",    32'(oDepStall), 32'd0);
        chk("ldw_dest",   32'(oDest), 32'd5);
        chk("ldw_op",     32'(oOpcode), 32'(OP_LDW));

        // LED MMIO store then load
        drive(OP_STW, 16'hF000, 16'hA5A5, 4'd0, 1'b0);
        step();
        chk("led_val",   32'(oLEDR), 32'hA5A5);
        chk("led_noreq", 32'(memBus.O_MemReq), 32'd0);
        chk("led_stall", 32'(oStall), 32'd0);
        drive(OP_LDW, 16'hF000, 16'h0, 4'd2, 1'b0);
        step();
        chk("ledld_data",  32'(oMemOut), 32'hA5A5);
        chk("ledld_noreq", 32'(memBus.O_MemReq), 32'd0);

        // Non-live LDW: passes through, no access, MemOut unchanged
        drive(OP_LDW, 16'h0020, 16'h0, 4'd4, 1'b1);
        step();
        chk("nl_noreq", 32'(memBus.O_MemReq), 32'd0);
        chk("nl_dep",   32'(oDepStall), 32'd1);
        chk("nl_mem",   32'(oMemOut), 32'hA5A5);

        // Ack arrives in the same cycle as the timeout: ack wins
        drive(OP_LDW, 16'h000A, 16'h0, 4'd6, 1'b0);
        step();
        chk("race_addr", 32'(memBus.O_MemAddr), 32'd5);
        step(); step(); step();
        chk("race_req3", 32'(memBus.O_MemReq), 32'd1);
        memBus.I_MemAck = 1'b1;
        memBus.I_MemRData = 16'h1111;
        step();
        memBus.I_MemAck = 1'b0;
        chk("race_err",  32'(oMemErr), 32'd0);
        chk("race_data", 32'(oMemOut), 32'h1111);
        chk("race_dep",  32'(oDepStall), 32'd0);

        // STW with no ack: timeout after 4 WAIT cycles
        drive(OP_STW, 16'h0006, 16'h5A5A, 4'd7, 1'b0);
        step();
        chk("to_addr",  32'(memBus.O_MemAddr), 32'd3);
        chk("to_we",    32'(memBus.O_MemWe), 32'd1);
        chk("to_wdata", 32'(memBus.O_MemWData), 32'h5A5A);
        step(); step(); step();
        chk("to_req3",  32'(memBus.O_MemReq), 32'd1);
        chk("to_err3",  32'(oMemErr), 32'd0);
        step();
        chk("to_req4",   32'(memBus.O_MemReq), 32'd0);
        chk("to_err4",   32'(oMemErr), 32'd1);
        chk("to_squash", 32'(oDepStall), 32'd1);
        chk("to_op",     32'(oOpcode), 32'(OP_STW));
        chk("to_stall",  32'(oStall), 32'd0);
        drive(OP_ADD_D, 16'h4321, 16'h0, 4'd8, 1'b0);
        step();
        chk("post_alu", 32'(oALUOut), 32'h4321);
        chk("post_dep", 32'(oDepStall), 32'd0);
        chk("post_err", 32'(oMemErr), 32'd1);

        // Reset during WAIT
        drive(OP_LDW, 16'h0040, 16'h0, 4'd9, 1'b0);
        step();
        chk("mr_req", 32'(memBus.O_MemReq), 32'd1);
        #2 rstN = 1'b0;
        #1;
        chk("mr_reqoff", 32'(memBus.O_MemReq), 32'd0);
        chk("mr_stall",  32'(oStall), 32'd0);
        chk("mr_err",    32'(oMemErr), 32'd0);
        chk("mr_led",    32'(oLEDR), 32'h0);
        step();
        rstN = 1'b1;
        drive(OP_ADD_D, 16'h0BAD, 16'h0, 4'd1, 1'b0);
        step();
        chk("mr_after", 32'(oALUOut), 32'h0BAD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
